gp_reg_file: RTL and testbench

GP_REG_FILE -- requirements
Module: gp_reg_file

---
 rtl/gp_reg_file_pkg.sv | 21 ++
 rtl/gp_reg_file_scoreboard.sv | 63 ++++++
 rtl/gp_reg_file.sv | 118 +++++++++++
 tb/tb_gp_reg_file.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/gp_reg_file_pkg.sv
// -----------------------------------------------------------------------------
// gp_reg_file_pkg
//   Shared constants and types for the general-purpose register file.
//   DEFAULT_WIDTH / DEFAULT_DEPTH : default register width and count
//   reg_idx_t                     : register index at the default depth
//   R0_IDX                        : index of register 0 (base-address register)
//   idx_width()                   : index width for a given depth (min 1 bit)
// -----------------------------------------------------------------------------
package gp_reg_file_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_DEPTH = 16;
  localparam int R0_IDX        = 0;

  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  typedef logic [idx_width(DEFAULT_DEPTH)-1:0] reg_idx_t;

endpackage

// File: rtl/gp_reg_file_scoreboard.sv
// -----------------------------------------------------------------------------
// gp_reg_file_scoreboard
//   Pending-bit bitmap: one bit per register, set when an instruction that
//   targets the register issues, cleared when the register is written back.
//   An issue and a write-back to the same register on one edge leave the bit
//   set, because the newly issued instruction still owes a result.
//   Ports:
//     clk, clr              : clock, async active-high reset
//     set_en / set_idx      : issue (already range-qualified by the caller)
//     clear_en / clear_idx  : write-back (already range-qualified)
//     rd_idx_x / rd_ok_x    : read index and its in-range flag, x = a, b
//     busy_a / busy_b       : registered pending flag after this edge's update
// -----------------------------------------------------------------------------
module gp_reg_file_scoreboard #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          set_en,
  input  logic [AW-1:0] set_idx,
  input  logic          clear_en,
  input  logic [AW-1:0] clear_idx,
  input  logic [AW-1:0] rd_idx_a,
  input  logic          rd_ok_a,
  input  logic [AW-1:0] rd_idx_b,
  input  logic          rd_ok_b,
  output logic          busy_a,
  output logic          busy_b
);

  logic [DEPTH-1:0] pend_q, pend_d;
  logic             busy_a_q, busy_a_d;
  logic             busy_b_q, busy_b_d;

  always_comb begin
    // NOTE: every combinational output gets a default before any branch so
    // no path leaves it unassigned, which would otherwise infer a latch.
    pend_d = pend_q;
    if (clear_en) pend_d[clear_idx] = 1'b0;
    // Set is applied after clear so the issue wins on a same-index collision.
    if (set_en)   pend_d[set_idx]   = 1'b1;
    // Busy reports the bitmap as it will stand after this edge.
    busy_a_d = rd_ok_a & pend_d[rd_idx_a];
    busy_b_d = rd_ok_b & pend_d[rd_idx_b];
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      pend_q   <= '0;
      busy_a_q <= 1'b0;
      busy_b_q <= 1'b0;
    end else begin
      pend_q   <= pend_d;
      busy_a_q <= busy_a_d;
      busy_b_q <= busy_b_d;
    end
  end

  assign busy_a = busy_a_q;
  assign busy_b = busy_b_q;

endmodule

// File: rtl/gp_reg_file.sv
// -----------------------------------------------------------------------------
// gp_reg_file
//   Two-read, one-write register file with registered read ports and a
//   per-register pending (scoreboard) flag.
//   Parameters: WIDTH (bits/register), DEPTH (register count; index width is
//   derived internally and need not be a power of two).
//   Ports:
//     clk, clr                 : clock, async active-high reset
//     wr_en/wr_addr/wr_data    : write port (also clears the pending bit)
//     rd_addr_a, rd_addr_b     : read indices, sampled every edge
//     BAout                    : base-address mode, reads of register 0 give 0
//     iss_en/iss_addr          : mark a register pending
//     rd_data_a/b, busy_a/b    : registered read data and pending flags
//   Indices >= DEPTH: writes/issues ignored, reads return 0 and not busy.
//   Build option GP_REG_FILE_BYPASS_EN: a read of the register being written
//   on the same edge returns the new data (write-first); otherwise the old
//   data is returned (read-first).
// -----------------------------------------------------------------------------
module gp_reg_file
  import gp_reg_file_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                        clk,
  input  logic                        clr,
  input  logic                        wr_en,
  input  logic [idx_width(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]            wr_data,
  input  logic [idx_width(DEPTH)-1:0] rd_addr_a,
  input  logic [idx_width(DEPTH)-1:0] rd_addr_b,
  input  logic                        BAout,
  input  logic                        iss_en,
  input  logic [idx_width(DEPTH)-1:0] iss_addr,
  output logic [WIDTH-1:0]            rd_data_a,
  output logic [WIDTH-1:0]            rd_data_b,
  output logic                        busy_a,
  output logic                        busy_b
);

  localparam int            AW        = idx_width(DEPTH);
  localparam logic [AW:0]   DEPTH_LIM = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] R0        = AW'(R0_IDX);

`ifdef GP_REG_FILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [WIDTH-1:0] rd_data_a_q, rd_data_a_d;
  logic [WIDTH-1:0] rd_data_b_q, rd_data_b_d;

  logic wr_ok, iss_ok, rd_ok_a, rd_ok_b;

  // Zero-extend by one bit so the limit compare stays meaningful when DEPTH
  // is an exact power of two.
  assign wr_ok   = wr_en  & ({1'b0, wr_addr}   < DEPTH_LIM);
  assign iss_ok  = iss_en & ({1'b0, iss_addr}  < DEPTH_LIM);
  assign rd_ok_a =          ({1'b0, rd_addr_a} < DEPTH_LIM);
  assign rd_ok_b =          ({1'b0, rd_addr_b} < DEPTH_LIM);

  always_comb begin
    mem_d = mem_q;
    if (wr_ok) mem_d[wr_addr] = wr_data;

    rd_data_a_d = '0;
    if (rd_ok_a && !(BAout && rd_addr_a == R0)) begin
      rd_data_a_d = (BYPASS && wr_ok && wr_addr == rd_addr_a) ? wr_data
                                                                : mem_q[rd_addr_a];
    end

    rd_data_b_d = '0;
    if (rd_ok_b && !(BAout && rd_addr_b == R0)) begin
      rd_data_b_d = (BYPASS && wr_ok && wr_addr == rd_addr_b) ? wr_data
                                                                : mem_q[rd_addr_b];
    end
  end

  // NOTE: the storage array sits on the async reset on purpose: every
  // register must read as zero while clr is held, so it cannot be left to a
  // reset-less RAM macro.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_data_a_q <= '0;
      rd_data_b_q <= '0;
    end else begin
      mem_q       <= mem_d;
      rd_data_a_q <= rd_data_a_d;
      rd_data_b_q <= rd_data_b_d;
    end
  end

  assign rd_data_a = rd_data_a_q;
  assign rd_data_b = rd_data_b_q;

  gp_reg_file_scoreboard #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_scoreboard (
    .clk       (clk),
    .clr       (clr),
    .set_en    (iss_ok),
    .set_idx   (iss_addr),
    .clear_en  (wr_ok),
    .clear_idx (wr_addr),
    .rd_idx_a  (rd_addr_a),
    .rd_ok_a   (rd_ok_a),
    .rd_idx_b  (rd_addr_b),
    .rd_ok_b   (rd_ok_b),
    .busy_a    (busy_a),
    .busy_b    (busy_b)
  );

endmodule

// File: tb/tb_gp_reg_file.sv
// -----------------------------------------------------------------------------
// tb_gp_reg_file
//   Directed bench for gp_reg_file at WIDTH=32, DEPTH=12 (non-power-of-two,
//   index width 4, so indices 12..15 are out of range). A vector table covers
//   single-cycle behaviour; short hand sequences cover reset and issue/write
//   interplay around clr.
// -----------------------------------------------------------------------------
module tb_gp_reg_file;

  localparam int W  = 32;
  localparam int D  = 12;
  localparam int AW = 4;

`ifdef GP_REG_FILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          clr;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [W-1:0]  wr_data;
  logic [AW-1:0] rd_addr_a, rd_addr_b;
  logic          BAout;
  logic          iss_en;
  logic [AW-1:0] iss_addr;
  logic [W-1:0]  rd_data_a, rd_data_b;
  logic          busy_a, busy_b;

  gp_reg_file #(.WIDTH(W), .DEPTH(D)) dut (
    .clk       (clk),
    .clr       (clr),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .BAout     (BAout),
    .iss_en    (iss_en),
    .iss_addr  (iss_addr),
    .rd_data_a (rd_data_a),
    .rd_data_b (rd_data_b),
    .busy_a    (busy_a),
    .busy_b    (busy_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    string         name;
    logic          we;
    logic [AW-1:0] wa;
    logic [W-1:0]  wd;
    logic [AW-1:0] ra;
    logic [AW-1:0] rb;
    logic          ba;
    logic          ie;
    logic [AW-1:0] ia;
    logic [W-1:0]  ea;
    logic [W-1:0]  eb;
    logic          eba;
    logic          ebb;
  } vec_t;

  vec_t vq[$];
  int   passed = 0;
  int   total  = 0;

  function automatic vec_t mk(string n, logic we, logic [AW-1:0] wa, logic [W-1:0] wd,
                              logic [AW-1:0] ra, logic [AW-1:0] rb, logic ba,
                              logic ie, logic [AW-1:0] ia, logic [W-1:0] ea,
                              logic [W-1:0] eb, logic eba, logic ebb);
    vec_t v;
    v.name = n; v.we = we; v.wa = wa; v.wd = wd; v.ra = ra; v.rb = rb; v.ba = ba;
    v.ie = ie; v.ia = ia; v.ea = ea; v.eb = eb; v.eba = eba; v.ebb = ebb;
    return v;
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else             passed++;
  endtask

  task automatic check_all(input string name, input logic [W-1:0] ea, input logic [W-1:0] eb,
                           input logic eba, input logic ebb);
    check({name, ".rd_data_a"}, rd_data_a, ea);
    check({name, ".rd_data_b"}, rd_data_b, eb);
    check({name, ".busy_a"}, W'(busy_a), W'(eba));
    check({name, ".busy_b"}, W'(busy_b), W'(ebb));
  endtask

  task automatic drive(input logic we, input logic [AW-1:0] wa, input logic [W-1:0] wd,
                       input logic [AW-1:0] ra, input logic [AW-1:0] rb, input logic ba,
                       input logic ie, input logic [AW-1:0] ia);
    wr_en = we; wr_addr = wa; wr_data = wd; rd_addr_a = ra; rd_addr_b = rb;
    BAout = ba; iss_en = ie; iss_addr = ia;
  endtask

  // Sample one time unit after the rising edge, well away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clr = 1'b1;
    drive(0, 0, '0, 0, 0, 0, 0, 0);
    #1;
    check_all("reset_hold", '0, '0, 0, 0);
    #12 clr = 1'b0;   // release mid-cycle (t=13)

    //       name           we wa  wd            ra  rb  ba ie ia  exp_a                             exp_b                             ba bb
    vq.push_back(mk("wr7",          1, 7,  32'hDEADBEEF, 1,  2,  0, 0, 0,  '0,                               '0,                               0, 0));
    vq.push_back(mk("rd7_both",     0, 0,  '0,           7,  7,  0, 0, 0,  32'hDEADBEEF,                     32'hDEADBEEF,                     0, 0));
    vq.push_back(mk("wr0",          1, 0,  32'h1234,     3,  3,  0, 0, 0,  '0,                               '0,                               0, 0));
    vq.push_back(mk("ba_on",        0, 0,  '0,           0,  0,  1, 0, 0,  '0,                               '0,                               0, 0));
    vq.push_back(mk("ba_off",       0, 0,  '0,           0,  0,  0, 0, 0,  32'h1234,                         32'h1234,                         0, 0));
    vq.push_back(mk("ba_per_port",  0, 0,  '0,           0,  7,  1, 0, 0,  '0,                               32'hDEADBEEF,                     0, 0));
    vq.push_back(mk("wr4_old",      1, 4,  32'h11,       0,  7,  0, 0, 0,  32'h1234,                         32'hDEADBEEF,                     0, 0));
    vq.push_back(mk("bypass4",      1, 4,  32'hA5A5A5A5, 4,  4,  0, 0, 0,  BYP ? 32'hA5A5A5A5 : 32'h11,      BYP ? 32'hA5A5A5A5 : 32'h11,      0, 0));
    vq.push_back(mk("rd4_after",    0, 0,  '0,           4,  4,  0, 0, 0,  32'hA5A5A5A5,                     32'hA5A5A5A5,                     0, 0));
    vq.push_back(mk("iss9",         0, 0,  '0,           9,  9,  0, 1, 9,  '0,                               '0,                               1, 1));
    vq.push_back(mk("wr_iss9",      1, 9,  32'h99,       1,  9,  0, 1, 9,  '0,                               BYP ? 32'h99 : 32'h0,             0, 1));
    vq.push_back(mk("wr9_clear",    1, 9,  32'h55,       9,  9,  0, 0, 0,  BYP ? 32'h55 : 32'h99,            BYP ? 32'h55 : 32'h99,            0, 0));
    vq.push_back(mk("oor_wr13",     1, 13, 32'hFF,       13, 1,  0, 1, 13, '0,                               '0,                               0, 0));
    vq.push_back(mk("oor_rd13",     0, 0,  '0,           13, 9,  0, 0, 0,  '0,                               32'h55,                           0, 0));
    vq.push_back(mk("oor_alias",    0, 0,  '0,           1,  5,  0, 0, 0,  '0,                               '0,                               0, 0));
    vq.push_back(mk("oor_top",      0, 0,  '0,           11, 15, 0, 0, 0,  '0,                               '0,                               0, 0));

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].we, vq[i].wa, vq[i].wd, vq[i].ra, vq[i].rb, vq[i].ba, vq[i].ie, vq[i].ia);
      step();
      check_all(vq[i].name, vq[i].ea, vq[i].eb, vq[i].eba, vq[i].ebb);
    end

    // Reg 3 written and issued on one edge: pending stays set.
    drive(1, 3, 32'h33, 7, 3, 0, 1, 3);
    step();
    check_all("pre_rst_wr3", 32'hDEADBEEF, BYP ? 32'h33 : 32'h0, 0, 1);
    drive(0, 0, '0, 7, 3, 0, 0, 0);
    step();
    check_all("pre_rst_rd3", 32'hDEADBEEF, 32'h33, 0, 1);

    // Mid-cycle clr pulse: outputs drop without a clock edge.
    #2 clr = 1'b1;
    #1;
    check_all("clr_async", '0, '0, 0, 0);
    // Write and issue presented across an edge while clr is high are dropped.
    drive(1, 3, 32'h77, 3, 3, 0, 1, 3);
    step();
    check_all("clr_hold_edge", '0, '0, 0, 0);
    #2 clr = 1'b0;

    // First edge after release is a normal cycle.
    drive(1, 2, 32'h22, 3, 7, 0, 0, 0);
    step();
    check_all("post_rst_rd3", '0, '0, 0, 0);
    drive(0, 0, '0, 2, 3, 0, 0, 0);
    step();
    check_all("post_rst_rd2", 32'h22, '0, 0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #20000;
    $display("FAIL timeout: simulation did not complete, got running expected done");
    $fatal(1);
  end

endmodule
